// File: rtl/layer_sequencer_pkg.sv
// rtl/layer_sequencer_pkg.sv - state encodings and width helper shared by layer controllers
package layer_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CH_LOAD = 3'd1,
        S_CONV    = 3'd2,
        S_TREE    = 3'd3,
        S_COUT    = 3'd4,
        S_POOL    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    // Index width for a channel count; a single channel still gets a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chan_idx_counter.sv
// rtl/chan_idx_counter.sv - nested input/output channel index counter with saturation flags
module chan_idx_counter
    import layer_sequencer_pkg::*;
#(
    parameter int IC = 3,
    parameter int OC = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  inc_ic,
    input  logic                  inc_oc_clr_ic,
    output logic [idx_w(IC)-1:0]  ic_idx,
    output logic [idx_w(OC)-1:0]  oc_idx,
    output logic                  last_ic,
    output logic                  last_oc
);

    localparam int ICW = idx_w(IC);
    localparam int OCW = idx_w(OC);

    assign last_ic = (ic_idx == ICW'(IC - 1));
    assign last_oc = (oc_idx == OCW'(OC - 1));

    // Increments are gated by the last flags so the indices saturate instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ic_idx <= '0;
            oc_idx <= '0;
        end else if (clr) begin
            ic_idx <= '0;
            oc_idx <= '0;
        end else if (inc_oc_clr_ic) begin
            ic_idx <= '0;
            if (!last_oc) begin
                oc_idx <= oc_idx + 1'b1;
            end
        end else if (inc_ic && !last_ic) begin
            ic_idx <= ic_idx + 1'b1;
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - per-layer control FSM stepping IC x OC channels through load/conv/tree/cout/pool
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int IC      = 3,
    parameter int OC      = 8,
    parameter int POOL_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  conv_done,
    input  logic                  tree_done,
    input  logic                  pool_done,
    output logic                  c_load,
    output logic                  conv,
    output logic                  tree,
    output logic                  cout,
    output logic                  pool,
    output logic [idx_w(IC)-1:0]  ic_idx,
    output logic [idx_w(OC)-1:0]  oc_idx,
    output logic                  busy,
    output logic                  layer_done
);

    state_t state;
    state_t state_next;
    logic   idx_clr;
    logic   idx_inc_ic;
    logic   idx_inc_oc;
    logic   last_ic;
    logic   last_oc;

    chan_idx_counter #(
        .IC(IC),
        .OC(OC)
    ) u_idx (
        .clk           (clk),
        .rst           (rst),
        .clr           (idx_clr),
        .inc_ic        (idx_inc_ic),
        .inc_oc_clr_ic (idx_inc_oc),
        .ic_idx        (ic_idx),
        .oc_idx        (oc_idx),
        .last_ic       (last_ic),
        .last_oc       (last_oc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_clr    = 1'b0;
        idx_inc_ic = 1'b0;
        idx_inc_oc = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_CH_LOAD;
                    idx_clr    = 1'b1;
                end
            end
            S_CH_LOAD: state_next = S_CONV;
            S_CONV: begin
                if (conv_done) begin
                    if (!last_ic) begin
                        idx_inc_ic = 1'b1;
                        state_next = S_CH_LOAD;
                    end else if (IC > 1) begin
                        state_next = S_TREE;
                    end else begin
                        state_next = S_COUT;
                    end
                end
            end
            S_TREE: begin
                if (tree_done) begin
                    state_next = S_COUT;
                end
            end
            S_COUT: begin
                if (!last_oc) begin
                    idx_inc_oc = 1'b1;
                    state_next = S_CH_LOAD;
                end else if (POOL_EN != 0) begin
                    state_next = S_POOL;
                end else begin
                    state_next = S_DONE;
                end
            end
            S_POOL: begin
                if (pool_done) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
                idx_clr    = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
                idx_clr    = 1'b1;
            end
        endcase
        // Abort overrides everything, including a simultaneous start in IDLE.
        if (abort) begin
            state_next = S_IDLE;
            idx_clr    = 1'b1;
            idx_inc_ic = 1'b0;
            idx_inc_oc = 1'b0;
        end
    end

    assign c_load     = (state == S_CH_LOAD);
    assign conv       = (state == S_CONV);
    assign tree       = (state == S_TREE);
    assign cout       = (state == S_COUT);
    assign pool       = (state == S_POOL);
    assign layer_done = (state == S_DONE);
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - randomized self-checking bench for three layer_sequencer configurations
`timescale 1ns/1ps
module tb_layer_sequencer;

    function automatic int p_ic(input int g);
        case (g)
            0: return 3;
            1: return 1;
            default: return 4;
        endcase
    endfunction

    function automatic int p_oc(input int g);
        case (g)
            0: return 2;
            1: return 1;
            default: return 8;
        endcase
    endfunction

    function automatic int p_pe(input int g);
        case (g)
            1: return 0;
            default: return 1;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_s [3];
    logic abort_s [3];
    logic cd [3];
    logic td [3];
    logic pd [3];
    logic c_load_o [3];
    logic conv_o [3];
    logic tree_o [3];
    logic cout_o [3];
    logic pool_o [3];
    logic busy_o [3];
    logic done_o [3];
    logic [7:0] ic_o [3];
    logic [7:0] oc_o [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int GIC = p_ic(g);
        localparam int GOC = p_oc(g);
        localparam int ICW = (GIC > 1) ? $clog2(GIC) : 1;
        localparam int OCW = (GOC > 1) ? $clog2(GOC) : 1;
        logic [ICW-1:0] ic_w;
        logic [OCW-1:0] oc_w;
        layer_sequencer #(
            .IC(GIC),
            .OC(GOC),
            .POOL_EN(p_pe(g))
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start_s[g]),
            .abort      (abort_s[g]),
            .conv_done  (cd[g]),
            .tree_done  (td[g]),
            .pool_done  (pd[g]),
            .c_load     (c_load_o[g]),
            .conv       (conv_o[g]),
            .tree       (tree_o[g]),
            .cout       (cout_o[g]),
            .pool       (pool_o[g]),
            .ic_idx     (ic_w),
            .oc_idx     (oc_w),
            .busy       (busy_o[g]),
            .layer_done (done_o[g])
        );
        assign ic_o[g] = 8'(ic_w);
        assign oc_o[g] = 8'(oc_w);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int ev(input int kind, input int oc, input int ic);
        return kind * 10000 + oc * 100 + ic;
    endfunction

    task automatic clear_inputs(input int d);
        start_s[d] = 1'b0;
        abort_s[d] = 1'b0;
        cd[d] = 1'b0;
        td[d] = 1'b0;
        pd[d] = 1'b0;
    endtask

    task automatic check_idle(input int d, input string name);
        checks++;
        if ({busy_o[d], c_load_o[d], conv_o[d], tree_o[d], cout_o[d], pool_o[d], done_o[d]} !== 7'b0 ||
            ic_o[d] !== 8'd0 || oc_o[d] !== 8'd0) begin
            errors++;
            $display("FAIL %s inst%0d: busy=%b outs=%b%b%b%b%b%b ic=%0d oc=%0d, required all 0",
                     name, d, busy_o[d], c_load_o[d], conv_o[d], tree_o[d], cout_o[d],
                     pool_o[d], done_o[d], ic_o[d], oc_o[d]);
        end
    endtask

    // Full layer with random done timing and noise; event order checked against nested-loop model.
    task automatic run_layer(input int d, input bit rnd_start, input string name);
        int exp_q[$];
        int got_q[$];
        int n;
        bit tree_prev;
        bit pool_prev;
        int hot;
        for (int o = 0; o < p_oc(d); o++) begin
            for (int i = 0; i < p_ic(d); i++) exp_q.push_back(ev(1, o, i));
            if (p_ic(d) > 1) exp_q.push_back(ev(2, o, 0));
            exp_q.push_back(ev(3, o, 0));
        end
        if (p_pe(d) != 0) exp_q.push_back(ev(4, 0, 0));
        exp_q.push_back(ev(5, 0, 0));
        start_s[d] = 1'b1;
        step();
        start_s[d] = 1'b0;
        n = 0;
        tree_prev = 1'b0;
        pool_prev = 1'b0;
        while (n < 3000) begin
            if (c_load_o[d]) got_q.push_back(ev(1, int'(oc_o[d]), int'(ic_o[d])));
            if (tree_o[d] && !tree_prev) got_q.push_back(ev(2, int'(oc_o[d]), 0));
            if (cout_o[d]) got_q.push_back(ev(3, int'(oc_o[d]), 0));
            if (pool_o[d] && !pool_prev) got_q.push_back(ev(4, 0, 0));
            if (done_o[d]) got_q.push_back(ev(5, 0, 0));
            tree_prev = tree_o[d];
            pool_prev = pool_o[d];
            hot = int'(c_load_o[d]) + int'(conv_o[d]) + int'(tree_o[d]) + int'(cout_o[d]) +
                  int'(pool_o[d]) + int'(done_o[d]);
            checks++;
            if (hot != 1 || !busy_o[d] || int'(ic_o[d]) > p_ic(d) - 1 || int'(oc_o[d]) > p_oc(d) - 1) begin
                errors++;
                $display("FAIL %s cycle%0d inst%0d: hot=%0d busy=%b ic=%0d oc=%0d, required hot=1 busy=1 ic<=%0d oc<=%0d",
                         name, n, d, hot, busy_o[d], ic_o[d], oc_o[d], p_ic(d) - 1, p_oc(d) - 1);
            end
            if (done_o[d]) break;
            cd[d] = ($urandom_range(0, 2) == 0);
            td[d] = ($urandom_range(0, 2) == 0);
            pd[d] = ($urandom_range(0, 2) == 0);
            start_s[d] = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            n++;
        end
        clear_inputs(d);
        checks++;
        if (!done_o[d]) begin
            errors++;
            $display("FAIL %s timeout: layer_done=%b after %0d cycles, required 1", name, done_o[d], n);
        end
        step();
        check_idle(d, {name, "_after"});
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s event_count: got %0d, required %0d", name, got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL %s event%0d: got %0d, required %0d", name, k, got_q[k], exp_q[k]);
            end
        end
    endtask

    // All dones held high: measure cycles from the start-sampling edge to layer_done.
    task automatic min_latency(input int d, input string name);
        int n;
        int req;
        bit tree_seen;
        req = p_oc(d) * (2 * p_ic(d) + ((p_ic(d) > 1) ? 1 : 0) + 1) + p_pe(d) + 1;
        cd[d] = 1'b1;
        td[d] = 1'b1;
        pd[d] = 1'b1;
        start_s[d] = 1'b1;
        step();
        start_s[d] = 1'b0;
        n = 1;
        tree_seen = tree_o[d];
        while (!done_o[d] && n < 1000) begin
            step();
            n++;
            tree_seen |= tree_o[d];
        end
        clear_inputs(d);
        checks++;
        if (n != req) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, required %0d", name, n, req);
        end
        checks++;
        if (tree_seen !== (p_ic(d) > 1)) begin
            errors++;
            $display("FAIL %s tree_seen: got %b, required %b", name, tree_seen, p_ic(d) > 1);
        end
        step();
        check_idle(d, {name, "_idle"});
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) clear_inputs(d);
        rst = 1'b1;
        step();
        step();
        for (int d = 0; d < 3; d++) check_idle(d, "reset");
        rst = 1'b0;
        step();
        for (int d = 0; d < 3; d++) check_idle(d, "post_reset");
    endtask

    task automatic test_single_channel();
        int n;
        string seq;
        seq = "";
        cd[1] = 1'b1;
        start_s[1] = 1'b1;
        step();
        start_s[1] = 1'b0;
        for (n = 1; n <= 4; n++) begin
            if (c_load_o[1]) seq = {seq, "L"};
            if (conv_o[1]) seq = {seq, "V"};
            if (tree_o[1]) seq = {seq, "T"};
            if (cout_o[1]) seq = {seq, "C"};
            if (done_o[1]) seq = {seq, "D"};
            if (n < 4) step();
        end
        checks++;
        if (seq != "LVCD") begin
            errors++;
            $display("FAIL single_seq: got %s, required LVCD", seq);
        end
        clear_inputs(1);
        step();
        check_idle(1, "single_idle");
        min_latency(1, "single_lat");
    endtask

    task automatic test_spurious();
        cd[0] = 1'b1;
        td[0] = 1'b1;
        pd[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_idle(0, "spurious_idle");
        end
        clear_inputs(0);
        start_s[0] = 1'b1;
        step();
        start_s[0] = 1'b0;
        checks++;
        if (c_load_o[0] !== 1'b1 || ic_o[0] !== 8'd0) begin
            errors++;
            $display("FAIL spurious_chload: c_load=%b ic=%0d, required 1 0", c_load_o[0], ic_o[0]);
        end
        cd[0] = 1'b1;
        td[0] = 1'b1;
        pd[0] = 1'b1;
        step();
        cd[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (conv_o[0] !== 1'b1 || ic_o[0] !== 8'd0 || oc_o[0] !== 8'd0) begin
                errors++;
                $display("FAIL spurious_conv%0d: conv=%b ic=%0d oc=%0d, required 1 0 0",
                         k, conv_o[0], ic_o[0], oc_o[0]);
            end
            step();
        end
        clear_inputs(0);
        abort_s[0] = 1'b1;
        step();
        abort_s[0] = 1'b0;
        check_idle(0, "spurious_abort");
    endtask

    task automatic test_abort();
        int n;
        start_s[0] = 1'b1;
        step();
        start_s[0] = 1'b0;
        n = 0;
        while (!(tree_o[0] && oc_o[0] == 8'd1) && n < 2000) begin
            cd[0] = ($urandom_range(0, 1) == 0);
            td[0] = 1'b0;
            pd[0] = ($urandom_range(0, 1) == 0);
            if (tree_o[0]) td[0] = 1'b1;
            step();
            n++;
        end
        checks++;
        if (!(tree_o[0] && oc_o[0] == 8'd1)) begin
            errors++;
            $display("FAIL abort_reach_tree: tree=%b oc=%0d, required 1 1", tree_o[0], oc_o[0]);
        end
        clear_inputs(0);
        abort_s[0] = 1'b1;
        step();
        abort_s[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_idle(0, "abort_idle");
            step();
        end
        run_layer(0, 1'b0, "abort_rerun");
    endtask

    task automatic test_async_rst();
        int n;
        start_s[0] = 1'b1;
        step();
        start_s[0] = 1'b0;
        n = 0;
        while (!conv_o[0] && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (conv_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_reach_conv: conv=%b, required 1", conv_o[0]);
        end
        #3;
        rst = 1'b1;
        #1;
        check_idle(0, "async_rst");
        step();
        rst = 1'b0;
        step();
        check_idle(0, "rst_release");
        start_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        step();
        clear_inputs(0);
        check_idle(0, "start_abort");
        run_layer(0, 1'b1, "busy_start");
    endtask

    task automatic test_big();
        run_layer(2, 1'b1, "big_rand");
        min_latency(2, "big_lat");
        min_latency(0, "small_lat");
    endtask

    initial begin
        test_reset();
        run_layer(0, 1'b0, "basic");
        test_single_channel();
        test_spurious();
        test_abort();
        test_async_rst();
        test_big();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
